// File: rtl/tcm_pkg.sv
// Shared definitions for the tightly-coupled-memory arbiter.
// Holds the outstanding-transaction state encoding, the requester IDs
// used to index one-hot grant vectors, and the byte-to-word address shift.
package tcm_pkg;

   // IDLE: nothing outstanding; PEND_*: one response owed to that requester
   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      PEND_IFU = 2'd1,
      PEND_LSU = 2'd2
   } tcm_state_e;

   // Bit positions inside the one-hot grant vector
   localparam logic SRC_IFU = 1'b0;
   localparam logic SRC_LSU = 1'b1;

   // Byte address bits below this index select a lane inside a word
   localparam int unsigned ADDR_LSB = 2;

endpackage

// File: rtl/tcm_arb_grant.sv
// Priority and starvation logic for the TCM arbiter.
// Ports:
//   ifuValid_i   - fetch request pending
//   lsuValid_i   - load/store request pending
//   canAccept_i  - the arbiter can take a new transaction this cycle
//   starveCnt_i  - consecutive cycles the fetch side has been refused
//   grant_o      - one-hot grant, indexed by SRC_IFU / SRC_LSU
//   starveCnt_o  - next value of the starvation counter
module tcm_arb_grant
   import tcm_pkg::*;
#(
   parameter int STARVE_MAX = 4,
   parameter int CW         = 3
) (
   input  logic          ifuValid_i,
   input  logic          lsuValid_i,
   input  logic          canAccept_i,
   input  logic [CW-1:0] starveCnt_i,
   output logic [1:0]    grant_o,
   output logic [CW-1:0] starveCnt_o
);

   localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

   logic starveForce;

   assign starveForce = (starveCnt_i == STARVE_LIM);

   // The load/store side normally wins a contested cycle; once the fetch
   // side has been refused often enough it takes the next contested grant.
   always_comb begin
      grant_o = '0;
      if (canAccept_i) begin
         if (ifuValid_i && lsuValid_i) begin
            if (starveForce) begin
               grant_o[SRC_IFU] = 1'b1;
            end else begin
               grant_o[SRC_LSU] = 1'b1;
            end
         end else begin
            grant_o[SRC_IFU] = ifuValid_i;
            grant_o[SRC_LSU] = lsuValid_i;
         end
      end
   end

   // Counts every cycle the fetch side asks and is refused, whether it lost
   // to the LSU or the arbiter was busy; saturates at the limit.
   always_comb begin
      starveCnt_o = starveCnt_i;
      if (grant_o[SRC_IFU]) begin
         starveCnt_o = '0;
      end else if (ifuValid_i && !starveForce) begin
         starveCnt_o = starveCnt_i + 1'b1;
      end
   end

endmodule

// File: rtl/tcm_arbiter.sv
// Two-requester arbiter in front of a single-port synchronous SRAM.
// The fetch unit (IFU) and the load/store unit (LSU) share one SRAM port;
// at most one access is outstanding, and its response appears the cycle
// after the grant. A new grant may be made in the same cycle the previous
// response is consumed, giving one access per cycle.
// Ports:
//   clk, rst_n                      - clock, synchronous active-low reset
//   ifu_req_* / ifu_rsp_*           - fetch request and response channels
//   lsu_req_* / lsu_rsp_*           - load/store request and response channels
//   ram_addr/ram_din/ram_we/ram_wem - SRAM command (word index, data, masks)
//   ram_dout                        - SRAM read data, one cycle after address
module tcm_arbiter
   import tcm_pkg::*;
#(
   parameter int AW         = 32,
   parameter int DW         = 32,
   parameter int MW         = 4,
   parameter int STARVE_MAX = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          ifu_req_valid,
   output logic          ifu_req_ready,
   input  logic [AW-1:0] ifu_req_addr,
   output logic          ifu_rsp_valid,
   input  logic          ifu_rsp_ready,
   output logic [DW-1:0] ifu_rsp_rdata,
   input  logic          lsu_req_valid,
   output logic          lsu_req_ready,
   input  logic [AW-1:0] lsu_req_addr,
   input  logic          lsu_req_we,
   input  logic [MW-1:0] lsu_req_wem,
   input  logic [DW-1:0] lsu_req_wdata,
   output logic          lsu_rsp_valid,
   input  logic          lsu_rsp_ready,
   output logic [DW-1:0] lsu_rsp_rdata,
   output logic [AW-1:0] ram_addr,
   output logic [DW-1:0] ram_din,
   output logic          ram_we,
   output logic [MW-1:0] ram_wem,
   input  logic [DW-1:0] ram_dout
);

   localparam int CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

   tcm_state_e    state_q, state_d;
   logic          isStore_q, isStore_d;
   logic [CW-1:0] starveCnt_q, starveCnt_d;
   logic [AW-1:0] lastRdAddr_q, lastRdAddr_d;

   logic          canAccept;
   logic [1:0]    grant;
   logic          grantIfu;
   logic          grantLsu;
   logic [AW-1:0] ifuWordAddr;
   logic [AW-1:0] lsuWordAddr;
   logic          unusedAddrBits;

   assign ifuWordAddr    = {{ADDR_LSB{1'b0}}, ifu_req_addr[AW-1:ADDR_LSB]};
   assign lsuWordAddr    = {{ADDR_LSB{1'b0}}, lsu_req_addr[AW-1:ADDR_LSB]};
   assign unusedAddrBits = ^{ifu_req_addr[ADDR_LSB-1:0], lsu_req_addr[ADDR_LSB-1:0]};

   // A new transaction fits when nothing is owed, or when the owed response
   // is being consumed this very cycle. Nothing is accepted during reset.
   always_comb begin
      canAccept = 1'b0;
      if (rst_n) begin
         unique case (state_q)
            IDLE:     canAccept = 1'b1;
            PEND_IFU: canAccept = ifu_rsp_ready;
            PEND_LSU: canAccept = lsu_rsp_ready;
            default:  canAccept = 1'b0;
         endcase
      end
   end

   tcm_arb_grant #(
      .STARVE_MAX (STARVE_MAX),
      .CW         (CW)
   ) u_grant (
      .ifuValid_i  (ifu_req_valid),
      .lsuValid_i  (lsu_req_valid),
      .canAccept_i (canAccept),
      .starveCnt_i (starveCnt_q),
      .grant_o     (grant),
      .starveCnt_o (starveCnt_d)
   );

   assign grantIfu      = grant[SRC_IFU];
   assign grantLsu      = grant[SRC_LSU];
   assign ifu_req_ready = grantIfu;
   assign lsu_req_ready = grantLsu;

   // Next-state logic: a consumed response returns to IDLE unless a new grant
   // in the same cycle moves straight to the next pending state. Only reads
   // record their word index, because stall cycles replay that index so the
   // SRAM keeps returning the pending read data.
   always_comb begin
      state_d      = state_q;
      isStore_d    = isStore_q;
      lastRdAddr_d = lastRdAddr_q;
      if (canAccept) begin
         state_d   = IDLE;
         isStore_d = 1'b0;
         if (grantIfu) begin
            state_d      = PEND_IFU;
            lastRdAddr_d = ifuWordAddr;
         end else if (grantLsu) begin
            state_d   = PEND_LSU;
            isStore_d = lsu_req_we;
            if (!lsu_req_we) begin
               lastRdAddr_d = lsuWordAddr;
            end
         end
      end
   end

   // SRAM command: the granted address in a grant cycle, otherwise the last
   // read index with writes disabled so the read data holds through stalls.
   always_comb begin
      ram_addr = lastRdAddr_q;
      ram_we   = 1'b0;
      if (grantIfu) begin
         ram_addr = ifuWordAddr;
      end else if (grantLsu) begin
         ram_addr = lsuWordAddr;
         ram_we   = lsu_req_we;
      end
   end

   assign ram_din = lsu_req_wdata;
   assign ram_wem = lsu_req_wem;

   // Responses come straight from the SRAM output; gating with rst_n drops a
   // pending response as soon as reset is asserted.
   assign ifu_rsp_valid = rst_n && (state_q == PEND_IFU);
   assign lsu_rsp_valid = rst_n && (state_q == PEND_LSU);
   assign ifu_rsp_rdata = ifu_rsp_valid ? ram_dout : '0;
   assign lsu_rsp_rdata = (lsu_rsp_valid && !isStore_q) ? ram_dout : '0;

   // State registers with synchronous reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         isStore_q    <= 1'b0;
         starveCnt_q  <= '0;
         lastRdAddr_q <= '0;
      end else begin
         state_q      <= state_d;
         isStore_q    <= isStore_d;
         starveCnt_q  <= starveCnt_d;
         lastRdAddr_q <= lastRdAddr_d;
      end
   end

endmodule

// File: tb/tb_tcm_arbiter.sv
// Randomized and directed bench for tcm_arbiter with a behavioural SRAM,
// a reference model of the arbitration rules and a response scoreboard.
module tb_tcm_arbiter;

   localparam int STARVE_MAX = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ifu_req_valid, ifu_req_ready, ifu_rsp_valid, ifu_rsp_ready;
   logic [31:0] ifu_req_addr, ifu_rsp_rdata;
   logic        lsu_req_valid, lsu_req_ready, lsu_req_we, lsu_rsp_valid, lsu_rsp_ready;
   logic [31:0] lsu_req_addr, lsu_req_wdata, lsu_rsp_rdata;
   logic [3:0]  lsu_req_wem;
   logic [31:0] ram_addr, ram_din, ram_dout;
   logic        ram_we;
   logic [3:0]  ram_wem;

   typedef struct {
      bit          src;
      logic [31:0] data;
      int          cyc;
   } exp_t;

   exp_t        expQ[$];
   int          vectors = 0;
   int          miscompares = 0;
   int          cyc = 0;
   int          pend;
   int          starve;
   logic [31:0] lastRd;
   logic [31:0] refMem[64];
   logic [31:0] sramMem[64];
   bit          memInit = 1'b0;

   tcm_arbiter #(
      .AW(32), .DW(32), .MW(4), .STARVE_MAX(STARVE_MAX)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .ifu_req_valid (ifu_req_valid),
      .ifu_req_ready (ifu_req_ready),
      .ifu_req_addr  (ifu_req_addr),
      .ifu_rsp_valid (ifu_rsp_valid),
      .ifu_rsp_ready (ifu_rsp_ready),
      .ifu_rsp_rdata (ifu_rsp_rdata),
      .lsu_req_valid (lsu_req_valid),
      .lsu_req_ready (lsu_req_ready),
      .lsu_req_addr  (lsu_req_addr),
      .lsu_req_we    (lsu_req_we),
      .lsu_req_wem   (lsu_req_wem),
      .lsu_req_wdata (lsu_req_wdata),
      .lsu_rsp_valid (lsu_rsp_valid),
      .lsu_rsp_ready (lsu_rsp_ready),
      .lsu_rsp_rdata (lsu_rsp_rdata),
      .ram_addr      (ram_addr),
      .ram_din       (ram_din),
      .ram_we        (ram_we),
      .ram_wem       (ram_wem),
      .ram_dout      (ram_dout)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] initWord(int i);
      if (i == 1) return 32'h1234_5678;
      if (i == 2) return 32'h0000_0037;
      return 32'hC0DE_0000 ^ (i * 32'h0101_0107);
   endfunction

   // Behavioural synchronous SRAM, loaded once on the first clock edge
   always @(posedge clk) begin
      if (!memInit) begin
         for (int i = 0; i < 64; i++) sramMem[i] <= initWord(i);
         memInit <= 1'b1;
      end else begin
         if (ram_we) begin
            for (int b = 0; b < 4; b++) begin
               if (ram_wem[b]) sramMem[ram_addr[5:0]][8*b +: 8] <= ram_din[8*b +: 8];
            end
         end
         ram_dout <= sramMem[ram_addr[5:0]];
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s at cycle %0d: got %08h, expected %08h", name, cyc, act, exp);
      end
   endtask

   // Drives one cycle of inputs at the falling edge, then advances the
   // reference model and checks the request-side outputs.
   task automatic applyStimulus(input logic rstIn,
                                input logic iv, input logic [31:0] ia, input logic irr,
                                input logic lv, input logic [31:0] la, input logic lwe,
                                input logic [3:0] lwem, input logic [31:0] lwd, input logic lrr);
      bit          canAcc, gI, gL;
      logic [31:0] expAddr;
      int          idx;
      @(negedge clk);
      rst_n         = rstIn;
      ifu_req_valid = iv;
      ifu_req_addr  = ia;
      ifu_rsp_ready = irr;
      lsu_req_valid = lv;
      lsu_req_addr  = la;
      lsu_req_we    = lwe;
      lsu_req_wem   = lwem;
      lsu_req_wdata = lwd;
      lsu_rsp_ready = lrr;
      #2;
      if (!rstIn) begin
         pend   = 0;
         starve = 0;
         lastRd = '0;
      end else begin
         canAcc = (pend == 0) || (pend == 1 && irr) || (pend == 2 && lrr);
         gI = 1'b0;
         gL = 1'b0;
         if (canAcc) begin
            if (iv && lv) begin
               if (starve == STARVE_MAX) gI = 1'b1;
               else gL = 1'b1;
            end else begin
               gI = iv;
               gL = lv;
            end
         end
         expAddr = gI ? (ia >> 2) : (gL ? (la >> 2) : lastRd);
         checkOutput("ifu_req_ready", 32'(ifu_req_ready), 32'(gI));
         checkOutput("lsu_req_ready", 32'(lsu_req_ready), 32'(gL));
         checkOutput("ram_we", 32'(ram_we), 32'(gL && lwe));
         checkOutput("ram_addr", ram_addr, expAddr);
         if (gL && lwe) begin
            checkOutput("ram_wem", 32'(ram_wem), 32'(lwem));
            checkOutput("ram_din", ram_din, lwd);
         end
         if (canAcc) pend = 0;
         if (gI) begin
            idx = int'(ia[7:2]);
            expQ.push_back('{src: 1'b0, data: refMem[idx], cyc: cyc});
            lastRd = ia >> 2;
            pend   = 1;
            starve = 0;
         end else if (gL) begin
            idx = int'(la[7:2]);
            if (lwe) begin
               expQ.push_back('{src: 1'b1, data: 32'h0, cyc: cyc});
               for (int b = 0; b < 4; b++) begin
                  if (lwem[b]) refMem[idx][8*b +: 8] = lwd[8*b +: 8];
               end
            end else begin
               expQ.push_back('{src: 1'b1, data: refMem[idx], cyc: cyc});
               lastRd = la >> 2;
            end
            pend = 2;
         end
         if (iv && !gI && starve < STARVE_MAX) starve++;
      end
   endtask

   task automatic idleCycle(input logic irr, input logic lrr);
      applyStimulus(1'b1, 1'b0, 32'h0, irr, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, lrr);
   endtask

   task automatic resetCycles(input int n);
      for (int i = 0; i < n; i++) begin
         applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b0);
      end
   endtask

   // Scoreboard monitor: compares every presented response with the oldest
   // expected one, and checks reset behaviour of the outputs.
   initial begin
      bit prevRst = 1'b0;
      forever begin
         @(negedge clk);
         #1;
         if (!rst_n) begin
            expQ.delete();
            checkOutput("reset ifu_rsp_valid", 32'(ifu_rsp_valid), 32'h0);
            checkOutput("reset lsu_rsp_valid", 32'(lsu_rsp_valid), 32'h0);
            checkOutput("reset ifu_rsp_rdata", ifu_rsp_rdata, 32'h0);
            checkOutput("reset lsu_rsp_rdata", lsu_rsp_rdata, 32'h0);
            checkOutput("reset ifu_req_ready", 32'(ifu_req_ready), 32'h0);
            checkOutput("reset lsu_req_ready", 32'(lsu_req_ready), 32'h0);
            checkOutput("reset ram_we", 32'(ram_we), 32'h0);
            if (prevRst) checkOutput("reset ram_addr", ram_addr, 32'h0);
            prevRst = 1'b1;
         end else begin
            prevRst = 1'b0;
            checkOutput("both rsp_valid", 32'(ifu_rsp_valid && lsu_rsp_valid), 32'h0);
            if (expQ.size() > 0 && expQ[0].cyc < cyc) begin
               checkOutput("ifu_rsp_valid", 32'(ifu_rsp_valid), 32'(expQ[0].src == 1'b0));
               checkOutput("lsu_rsp_valid", 32'(lsu_rsp_valid), 32'(expQ[0].src == 1'b1));
               if (expQ[0].src == 1'b0) begin
                  checkOutput("ifu_rsp_rdata", ifu_rsp_rdata, expQ[0].data);
                  if (ifu_rsp_ready) void'(expQ.pop_front());
               end else begin
                  checkOutput("lsu_rsp_rdata", lsu_rsp_rdata, expQ[0].data);
                  if (lsu_rsp_ready) void'(expQ.pop_front());
               end
            end else begin
               checkOutput("idle ifu_rsp_valid", 32'(ifu_rsp_valid), 32'h0);
               checkOutput("idle lsu_rsp_valid", 32'(lsu_rsp_valid), 32'h0);
            end
         end
      end
   end

   initial begin
      rst_n = 1'b0;
      ifu_req_valid = 1'b0; ifu_req_addr = '0; ifu_rsp_ready = 1'b0;
      lsu_req_valid = 1'b0; lsu_req_addr = '0; lsu_req_we = 1'b0;
      lsu_req_wem = '0; lsu_req_wdata = '0; lsu_rsp_ready = 1'b0;
      pend = 0; starve = 0; lastRd = '0;
      for (int i = 0; i < 64; i++) refMem[i] = initWord(i);

      resetCycles(2);

      // Stalled fetch: word 2 held for four cycles while the consumer stalls
      $display("[TB] stalled read");
      applyStimulus(1'b1, 1'b1, 32'h8, 1'b0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 1'b1, 32'hC, 1'b0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b0);
         checkOutput("stall ifu_rsp_valid", 32'(ifu_rsp_valid), 32'h1);
         checkOutput("stall ifu_rsp_rdata", ifu_rsp_rdata, 32'h0000_0037);
         checkOutput("stall ifu_req_ready", 32'(ifu_req_ready), 32'h0);
      end
      idleCycle(1'b1, 1'b0);
      checkOutput("stall last ifu_rsp_rdata", ifu_rsp_rdata, 32'h0000_0037);
      idleCycle(1'b1, 1'b1);

      // Partial store followed by a load of the same word
      $display("[TB] store then load");
      resetCycles(1);
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h4, 1'b1, 4'b0011, 32'hAAAA_BBBB, 1'b1);
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h4, 1'b0, 4'b0000, 32'h0, 1'b1);
      checkOutput("store lsu_rsp_rdata", lsu_rsp_rdata, 32'h0);
      idleCycle(1'b1, 1'b1);
      checkOutput("load lsu_rsp_rdata", lsu_rsp_rdata, 32'h1234_BBBB);
      idleCycle(1'b1, 1'b1);

      // Continuous contention: four LSU grants then one IFU grant
      $display("[TB] starvation");
      resetCycles(1);
      for (int i = 0; i < 10; i++) begin
         applyStimulus(1'b1, 1'b1, 32'(i * 4), 1'b1, 1'b1, 32'(64 + i * 4), 1'b0, 4'h0, 32'h0, 1'b1);
         checkOutput("starve pattern ifu", 32'(ifu_req_ready), 32'(i % 5 == 4));
         checkOutput("starve pattern lsu", 32'(lsu_req_ready), 32'(i % 5 != 4));
      end
      idleCycle(1'b1, 1'b1);
      idleCycle(1'b1, 1'b1);

      // Back-to-back fetches of words 0, 1, 2
      $display("[TB] back-to-back reads");
      resetCycles(1);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 1'b1, 32'(i * 4), 1'b1, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b1);
         if (i > 0) checkOutput("b2b ifu_rsp_valid", 32'(ifu_rsp_valid), 32'h1);
      end
      idleCycle(1'b1, 1'b1);
      checkOutput("b2b last ifu_rsp_valid", 32'(ifu_rsp_valid), 32'h1);
      idleCycle(1'b1, 1'b1);

      // Reset right after a load grant drops its response
      $display("[TB] reset mid-operation");
      resetCycles(1);
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h8, 1'b0, 4'h0, 32'h0, 1'b1);
      resetCycles(2);
      applyStimulus(1'b1, 1'b1, 32'h4, 1'b1, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b1);
      idleCycle(1'b1, 1'b1);
      idleCycle(1'b1, 1'b1);

      // Randomized traffic with occasional resets
      $display("[TB] random traffic");
      for (int i = 0; i < 1500; i++) begin
         applyStimulus(1'($urandom_range(0, 99) != 0),
                       1'($urandom_range(0, 9) < 6), 32'($urandom_range(0, 255)),
                       1'($urandom_range(0, 9) < 7),
                       1'($urandom_range(0, 9) < 6), 32'($urandom_range(0, 255)),
                       1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                       32'($urandom), 1'($urandom_range(0, 9) < 7));
      end
      idleCycle(1'b1, 1'b1);
      idleCycle(1'b1, 1'b1);
      idleCycle(1'b1, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/tcm_arbiter.md
TCM_ARBITER -- requirements
Module: tcm_arbiter

Interface
REQ-001 SHALL have parameter AW, default 32: address width of both requesters and of the RAM port.
REQ-002 SHALL have parameter DW, default 32: data width.
REQ-003 SHALL have parameter MW, default 4: byte write-mask width.
REQ-004 SHALL have parameter STARVE_MAX, default 4: the number of consecutive IFU denials that forces an IFU grant.
REQ-005 SHALL have one clock; reset is synchronous and active-low.
REQ-006 Ports, in order:
  clk  in  1  clock, all logic on rising edge
  rst_n  in  1  synchronous active-low reset
  ifu_req_valid  in  1  fetch request
  ifu_req_ready  out  1  fetch request accepted
  ifu_req_addr  in  AW  fetch byte address
  ifu_rsp_valid  out  1  fetch data valid
  ifu_rsp_ready  in  1  fetch data consumed
  ifu_rsp_rdata  out  DW  fetch data
  lsu_req_valid  in  1  load/store request
  lsu_req_ready  out  1  load/store request accepted
  lsu_req_addr  in  AW  load/store byte address
  lsu_req_we  in  1  1=store, 0=load
  lsu_req_wem  in  MW  byte mask for a store, already lane-aligned
  lsu_req_wdata  in  DW  store data, already lane-aligned
  lsu_rsp_valid  out  1  load data / store completion
  lsu_rsp_ready  in  1  response consumed
  lsu_rsp_rdata  out  DW  load data; 0 for a store
  ram_addr  out  AW  word index to the SRAM
  ram_din  out  DW  SRAM write data
  ram_we  out  1  SRAM write enable
  ram_wem  out  MW  SRAM byte mask
  ram_dout  in  DW  SRAM read data, valid one cycle after a read address is presented

Function
REQ-007 SHALL accept a request only on the cycle where valid & ready are both high; ready SHALL NOT depend on the requester's own valid.
REQ-008 SHALL drive the RAM port combinationally in the grant cycle: ram_addr = {2'b0, req_addr[AW-1:2]}; ram_we = lsu_req_we only for an LSU grant; ram_wem = lsu_req_wem; ram_din = lsu_req_wdata.
REQ-009 SHALL present the response exactly one cycle after the grant, with rdata taken from ram_dout, or 0 for a store.
REQ-010 SHALL allow at most one outstanding transaction, tracked by FSM states IDLE, PEND_IFU and PEND_LSU.
REQ-011 Transitions: IDLE -> PEND_x on a grant to x. PEND_x -> IDLE when rsp_ready is high and there is no new grant. PEND_x -> PEND_y when rsp_ready is high and a new grant is made in the same cycle (back-to-back, one access per cycle).
REQ-012 SHALL deassert both req_ready outputs while in PEND_x with x_rsp_ready low.
REQ-013 SHALL hold x_rsp_valid and x_rsp_rdata stable while stalled.
REQ-014 Stall stability rule: on every non-grant cycle, ram_addr = last_rd_addr and ram_we = 0.
REQ-015 last_rd_addr SHALL update only on read grants; store grants SHALL NOT update it.
REQ-016 Arbitration: LSU has priority over IFU when both are valid.
REQ-017 Starvation: starve_cnt SHALL increment when the IFU is valid and not granted. It SHALL clear on any IFU grant. When starve_cnt == STARVE_MAX, the IFU SHALL win the next contested grant.
REQ-018 SHALL never assert both req_ready outputs in the same cycle; the loser's ready SHALL be 0.
REQ-019 SHALL keep starve_cnt unchanged when IFU valid is low; it saturates at STARVE_MAX.
REQ-020 SHALL never assert ifu_rsp_valid and lsu_rsp_valid together.

Reset
REQ-021 On rst_n low at a clock edge, the following SHALL all be 0: state = IDLE, starve_cnt, last_rd_addr, both rsp_valid, both rsp_rdata.
REQ-022 While rst_n is low, both req_ready outputs SHALL be 0 and ram_we SHALL be 0.
REQ-023 Reset mid-transaction SHALL drop the pending response with no response issued. A store granted in the same cycle as reset SHALL NOT reach the RAM.

Structure
REQ-024 The shared package tcm_pkg SHALL hold:
  - FSM state encoding (IDLE, PEND_IFU, PEND_LSU);
  - source-ID constants SRC_IFU and SRC_LSU;
  - word-offset constant ADDR_LSB = 2.
REQ-025 One sub-module, tcm_arb_grant, SHALL contain the priority and starvation logic. Its inputs are the two valids, the can-accept signal and starve_cnt. Its outputs are the one-hot grant and the next starve_cnt.

Verification
REQ-026 Stalled read: IFU reads 0x8, RAM word 2 = 0x0000_0037, ifu_rsp_ready held low 3 cycles -> ifu_rsp_valid high from cycle 1 with rdata 0x0000_0037 constant for 4 cycles; ifu_req_ready = 0 throughout.
REQ-027 Store then load: LSU store to 0x4, wem 4'b0011, wdata 0xAAAA_BBBB over 0x1234_5678, then load 0x4 -> lsu_rsp_rdata = 0 for the store and 0x1234_BBBB for the load.
REQ-028 Starvation: IFU and LSU both valid continuously, STARVE_MAX = 4 -> grant pattern L,L,L,L,I repeating; no two responses in one cycle.
REQ-029 Back-to-back reads: IFU reads 0x0, 0x4, 0x8 with rsp_ready tied high -> three responses in consecutive cycles, no gaps.
REQ-030 Reset mid-operation: rst_n low in the cycle after an LSU load grant -> no lsu_rsp_valid; all outputs 0 the next cycle; normal operation after release.
